instr_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle core's instruction fetcher.
- Accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them sequentially into instruction memory starting at word 0.
- Holds the core in reset until a complete, well-formed image has been loaded.
- Reloadable on request without a global reset.

---
 rtl/instr_loader_pkg.sv | 17 +
 rtl/instr_loader_if.sv | 21 ++
 rtl/instr_loader_word_assembler.sv | 33 +++
 rtl/instr_loader.sv | 126 ++++++++++++
 tb/tb_instr_loader.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and widths for the boot-time instruction loader.
package instr_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the loader.
interface instr_loader_if import instr_loader_pkg::*; #(
    parameter int ADDR_W = 10
);
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Packs four accepted bytes into one little-endian 32-bit word.
module instr_loader_word_assembler import instr_loader_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_strobe,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [1:0]               idx_p0;
    logic [WORD_W-BYTE_W-1:0] shift_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_p0 <= '0;
        end else if (clear) begin
            idx_p0 <= '0;
        end else if (byte_strobe) begin
            idx_p0 <= idx_p0 + 2'd1;
        end
    end

    // stage p0: earlier bytes shift down so the first byte lands in [7:0]
    always_ff @(posedge clk) begin
        if (byte_strobe) begin
            shift_p0 <= {byte_in, shift_p0[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign word       = {byte_in, shift_p0};
    assign word_valid = byte_strobe && (idx_p0 == 2'd3);
endmodule

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed byte stream -> sequential imem writes, core held in reset until done.
// Build option LOADER_CSUM_EN appends and verifies an XOR checksum byte after the data.
module instr_loader import instr_loader_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    instr_loader_if.slave      bus,
    output logic               core_rst,
    output logic               load_done,
    output logic               load_err,
    output logic [COUNT_W-1:0] word_count
);
    localparam logic [COUNT_W:0] DEPTH_L = (COUNT_W+1)'(DEPTH);
`ifdef LOADER_CSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    state_t               state_q, state_d;
    logic                 armed_q;
    logic [BYTE_W-1:0]    len_hi_q;
    logic [COUNT_W-1:0]   len_q;
    logic [COUNT_W-1:0]   len_next;
    logic                 accepting, xfer, restart, last_word;
    logic                 asm_valid;
    logic [WORD_W-1:0]    asm_word;
`ifdef LOADER_CSUM_EN
    logic [BYTE_W-1:0]    csum_q;
`endif

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    // byte_ready stays low until the first edge after reset release
    assign accepting = armed_q && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                                   state_q == S_DATA   || state_q == S_CSUM);
    assign xfer      = bus.byte_valid && accepting;
    assign restart   = start && (state_q == S_DONE || state_q == S_ERR);
    assign len_next  = {len_hi_q, bus.byte_in};
    assign last_word = sat_inc(word_count) == len_q;

    assign bus.byte_ready = accepting;
    assign core_rst       = (state_q != S_DONE);
    assign load_done      = (state_q == S_DONE);
    assign load_err       = (state_q == S_ERR);

    instr_loader_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (restart),
        .byte_in     (bus.byte_in),
        .byte_strobe (xfer && state_q == S_DATA),
        .word        (asm_word),
        .word_valid  (asm_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_next} > DEPTH_L) state_d = S_ERR;
                    else if (len_next == '0)        state_d = AFTER_DATA;
                    else                            state_d = S_DATA;
                end
            end
            S_DATA:   if (asm_valid && last_word) state_d = AFTER_DATA;
`ifdef LOADER_CSUM_EN
            S_CSUM:   if (xfer) state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            default:  state_d = S_ERR;
        endcase
    end

    // stage p0: length capture, word write strobe and running word count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q        <= 1'b0;
            len_hi_q       <= '0;
            len_q          <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            word_count     <= '0;
        end else begin
            armed_q     <= 1'b1;
            bus.imem_we <= 1'b0;
            if (restart) word_count <= '0;
            if (xfer && state_q == S_LEN_HI) len_hi_q <= bus.byte_in;
            if (xfer && state_q == S_LEN_LO) len_q    <= len_next;
            if (asm_valid) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_count[ADDR_W-1:0];
                bus.imem_wdata <= asm_word;
                word_count     <= sat_inc(word_count);
            end
        end
    end

`ifdef LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (restart) begin
            csum_q <= '0;
        end else if (xfer && state_q == S_DATA) begin
            csum_q <= csum_q ^ bus.byte_in;
        end
    end
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Directed, table-driven bench for instr_loader; adapts expectations when LOADER_CSUM_EN is defined.
module tb_instr_loader;
    import instr_loader_pkg::*;

`ifdef LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        core_rst, load_done, load_err;
    logic [15:0] word_count;

    instr_loader_if #(.ADDR_W(10)) bus();

    instr_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    logic [31:0] mem_seen [16];

    typedef struct {
        logic [15:0]       n;
        logic [3:0][31:0]  w;
        logic [7:0]        flip;
        bit                gaps;
        bit                exp_done;
        bit                exp_err;
        int                exp_wr;
        logic [15:0]       exp_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            check("write address order", 32'(bus.imem_addr), 32'(wr_cnt));
            if (bus.imem_addr < 10'd16) mem_seen[bus.imem_addr[3:0]] = bus.imem_wdata;
            wr_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("byte_ready timeout", 32'(t), 32'd0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_image(input logic [15:0] n, input logic [15:0][31:0] words,
                              input logic [7:0] flip, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        if (n <= 16'd16) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < 4; j++) begin
                    b  = words[i][8*j +: 8];
                    cs = cs ^ b;
                    send_byte(b, gaps ? int'($urandom_range(0, 1)) : 0);
                end
            end
            if (CSUM_ON) send_byte(cs ^ flip, 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart core_rst", 32'(core_rst), 32'd1);
        check("restart load_done", 32'(load_done), 32'd0);
        check("restart load_err", 32'(load_err), 32'd0);
        check("restart word_count", 32'(word_count), 32'd0);
        wr_cnt = 0;
        for (int k = 0; k < 16; k++) mem_seen[k] = 32'hx;
    endtask

    initial begin
        logic [15:0][31:0] img;

        tbl[0] = '{16'd2,      {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678}, 8'h00, 1'b0, 1'b1, 1'b0, 2, 16'd2};
        tbl[1] = '{16'h0401,   {32'h0, 32'h0, 32'h0, 32'h0},               8'h00, 1'b0, 1'b0, 1'b1, 0, 16'd0};
        tbl[2] = '{16'd1,      {32'h0, 32'h0, 32'h0, 32'h000000FF},        8'hFF, 1'b0, !CSUM_ON, CSUM_ON, 1, 16'd1};
        tbl[3] = '{16'd1,      {32'h0, 32'h0, 32'h0, 32'h000000FF},        8'h00, 1'b0, 1'b1, 1'b0, 1, 16'd1};
        tbl[4] = '{16'd0,      {32'h0, 32'h0, 32'h0, 32'h0},               8'h00, 1'b0, 1'b1, 1'b0, 0, 16'd0};
        tbl[5] = '{16'd3,      {32'h0, 32'h80000000, 32'h00000001, 32'hCAFEF00D}, 8'h00, 1'b1, 1'b1, 1'b0, 3, 16'd3};

        rst            = 1'b0;
        start          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        #1;
        check("reset byte_ready", 32'(bus.byte_ready), 32'd0);
        check("reset core_rst", 32'(core_rst), 32'd1);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset load_err", 32'(load_err), 32'd0);
        check("reset word_count", 32'(word_count), 32'd0);
        check("reset imem_we", 32'(bus.imem_we), 32'd0);
        check("reset imem_addr", 32'(bus.imem_addr), 32'd0);
        check("reset imem_wdata", bus.imem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("byte_ready before first edge", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        check("byte_ready after first edge", 32'(bus.byte_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (i > 0) pulse_start();
            img = '0;
            img[3:0] = tbl[i].w;
            send_image(tbl[i].n, img, tbl[i].flip, tbl[i].gaps);
            @(negedge clk);
            check($sformatf("vec%0d load_done", i), 32'(load_done), 32'(tbl[i].exp_done));
            check($sformatf("vec%0d load_err", i), 32'(load_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d core_rst", i), 32'(core_rst), 32'(!tbl[i].exp_done));
            check($sformatf("vec%0d word_count", i), 32'(word_count), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d byte_ready", i), 32'(bus.byte_ready), 32'd0);
            check($sformatf("vec%0d writes", i), 32'(wr_cnt), 32'(tbl[i].exp_wr));
            for (int k = 0; k < tbl[i].exp_wr; k++)
                check($sformatf("vec%0d mem[%0d]", i, k), mem_seen[k], tbl[i].w[k]);
        end

        // 16-word image with random valid gaps
        pulse_start();
        for (int i = 0; i < 16; i++) img[i] = 32'h01020304 * (i + 1) ^ 32'hA5000000;
        send_image(16'd16, img, 8'h00, 1'b1);
        @(negedge clk);
        check("gap load_done", 32'(load_done), 32'd1);
        check("gap word_count", 32'(word_count), 32'd16);
        check("gap writes", 32'(wr_cnt), 32'd16);
        for (int k = 0; k < 16; k++) check($sformatf("gap mem[%0d]", k), mem_seen[k], img[k]);

        // asynchronous reset after 6 of 8 data bytes
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        send_byte(8'h88, 0);
        send_byte(8'h77, 0);
        check("midload word_count", 32'(word_count), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midload rst core_rst", 32'(core_rst), 32'd1);
        check("midload rst word_count", 32'(word_count), 32'd0);
        check("midload rst imem_we", 32'(bus.imem_we), 32'd0);
        check("midload rst imem_addr", 32'(bus.imem_addr), 32'd0);
        check("midload rst byte_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset byte_ready", 32'(bus.byte_ready), 32'd1);
        wr_cnt = 0;
        img = '0;
        img[0] = 32'h0BADF00D;
        send_image(16'd1, img, 8'h00, 1'b0);
        @(negedge clk);
        check("reload load_done", 32'(load_done), 32'd1);
        check("reload core_rst", 32'(core_rst), 32'd0);
        check("reload writes", 32'(wr_cnt), 32'd1);
        check("reload mem[0]", mem_seen[0], 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
